any_mux: RTL and testbench

//   Parameterised N:1 single-bit multiplexer. I[S] drives Y combinationally.
//   An optional registered copy, Y_q, lets downstream logic take a timed-out

---
 rtl/any_mux_pkg.sv | 10 +
 rtl/any_mux_mux2.sv | 12 +
 rtl/any_mux.sv | 63 ++++++
 tb/tb_any_mux.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/any_mux_pkg.sv
// Shared helpers for the any_mux bit-select primitive.
package any_mux_pkg;

    // Offset of tree level l inside the flattened node vector of a p-level tree.
    // Level 0 holds the 2**p padded leaves and the last level holds the root.
    function automatic int unsigned lvl_off(input int unsigned p, input int unsigned l);
        return (32'd1 << (p + 32'd1)) - (32'd1 << (p + 32'd1 - l));
    endfunction

endpackage

// File: rtl/any_mux_mux2.sv
// 2:1 single-bit mux, one node of the select tree.
module any_mux_mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    // A known sel passes X/Z on the chosen input through and ignores the other one.
    assign y = sel ? b : a;

endmodule

// File: rtl/any_mux.sv
// N:1 single-bit mux built as a log2 tree, with a registered copy and a range flag.
module any_mux
    import any_mux_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned P = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] I,
    input  logic [P-1:0] S,
    input  logic         en,
    output logic         Y,
    output logic         Y_q,
    output logic         sel_err
);

    localparam int unsigned LEAVES = 32'd1 << P;
    localparam int unsigned NODES  = 2 * LEAVES - 1;

    if (N < 2 || P != $clog2(N)) begin : g_bad
        $error("any_mux: illegal parameters N=%0d P=%0d (need N>=2, P==$clog2(N))", N, P);
        assign Y       = 1'b0;
        assign Y_q     = 1'b0;
        assign sel_err = 1'b0;
    end else begin : g_mux
        logic [NODES-1:0] node;

        // Leaves: real inputs, then constant 0 up to 2**P so S >= N selects 0.
        for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
            if (k < N) begin : g_in
                assign node[k] = I[k];
            end else begin : g_pad
                assign node[k] = 1'b0;
            end
        end

        // Level l halves the candidates using select bit S[l].
        for (genvar l = 0; l < P; l++) begin : g_lvl
            for (genvar j = 0; j < (LEAVES >> (l + 1)); j++) begin : g_node
                any_mux_mux2 u_mux2 (
                    .a   (node[lvl_off(P, l) + 2 * j]),
                    .b   (node[lvl_off(P, l) + 2 * j + 1]),
                    .sel (S[l]),
                    .y   (node[lvl_off(P, l + 1) + j])
                );
            end
        end

        assign Y       = node[NODES-1];
        assign sel_err = ({1'b0, S} >= (P + 1)'(N));

        // Registered copy of Y; reset clears it at once and holds it while asserted.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                Y_q <= 1'b0;
            end else if (en) begin
                Y_q <= Y;
            end
        end
    end

endmodule

// File: tb/tb_any_mux.sv
// Bench for any_mux: directed steps for N=4 and N=5, random vectors for N=8.
module tb_any_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;

    logic [3:0] i4;
    logic [1:0] s4;
    logic       y4, yq4, err4;

    logic [4:0] i5;
    logic [2:0] s5;
    logic       y5, yq5, err5;

    logic [7:0] i8;
    logic [2:0] s8;
    logic       y8, yq8, err8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    any_mux #(4, 2) u4 (
        .clk(clk), .rst(rst), .I(i4), .S(s4), .en(en),
        .Y(y4), .Y_q(yq4), .sel_err(err4)
    );

    any_mux #(5, 3) u5 (
        .clk(clk), .rst(rst), .I(i5), .S(s5), .en(en),
        .Y(y5), .Y_q(yq5), .sel_err(err5)
    );

    any_mux #(8, 3) u8 (
        .clk(clk), .rst(rst), .I(i8), .S(s8), .en(en),
        .Y(y8), .Y_q(yq8), .sel_err(err8)
    );

    // Reference: bit s of the input word, or 0 once s runs past the N real inputs.
    function automatic logic ref_y(input logic [7:0] vec, input int n, input int s);
        if (s >= n) return 1'b0;
        return logic'((vec >> s) & 8'd1);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic q_model;
        logic q_next;
        logic q_valid;
        logic r;

        // 1. reset state
        rst = 1'b1; en = 1'b0;
        i4 = 4'b0000; s4 = 2'd0;
        i5 = 5'b00000; s5 = 3'd0;
        i8 = 8'h00; s8 = 3'd0;
        #1;
        check("rst_y", y4, 1'b0);
        check("rst_yq", yq4, 1'b0);
        check("rst_err", err4, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;

        // 2. walk S over I=1010
        i4 = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            s4 = 2'(s);
            #10;
            check($sformatf("walk_y_s%0d", s), y4, ref_y({4'b0, i4}, 4, s));
            check($sformatf("walk_err_s%0d", s), err4, 1'b0);
        end

        // 3. load Y_q, then hold with en=0
        @(posedge clk); #2;
        en = 1'b1; i4 = 4'b0100; s4 = 2'd2;
        #1;
        check("load_y_comb", y4, 1'b1);
        @(posedge clk); #1;
        check("load_yq", yq4, 1'b1);
        en = 1'b0; s4 = 2'd0;
        #1;
        check("hold_y", y4, 1'b0);
        @(posedge clk); #1;
        check("hold_yq", yq4, 1'b1);

        // 4. asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_yq", yq4, 1'b0);
        i4 = 4'b0001; s4 = 2'd0; en = 1'b1;
        #1;
        check("rst_y_tracks", y4, 1'b1);
        @(posedge clk); #1;
        check("rst_held_yq", yq4, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_load_yq", yq4, 1'b1);
        en = 1'b0;

        // 5. non-power-of-two N=5, padded leaves
        i5 = 5'b10000;
        for (int s = 0; s < 8; s++) begin
            s5 = 3'(s);
            #1;
            check($sformatf("n5_y_s%0d", s), y5, ref_y({3'b0, i5}, 5, s));
            check($sformatf("n5_err_s%0d", s), err5, logic'(s >= 5));
        end

        // 6. random vectors, N=8
        q_model = 1'b0;
        q_valid = 1'b0;
        @(posedge clk); #2;
        for (int v = 0; v < 100; v++) begin
            i8 = 8'($urandom);
            s8 = 3'($urandom_range(0, 7));
            en = (v == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            r = ref_y(i8, 8, int'(s8));
            check($sformatf("rand_y_%0d", v), y8, r);
            check($sformatf("rand_err_%0d", v), err8, 1'b0);
            q_next = en ? r : q_model;
            if (en) q_valid = 1'b1;
            @(posedge clk); #1;
            q_model = q_next;
            if (q_valid) check($sformatf("rand_yq_%0d", v), yq8, q_model);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
